// File: rtl/test_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : test_mon_pkg
// Purpose  : Shared types and constants for the end-of-test status monitor.
//            Holds the FSM state encoding, the ISA-test register indices
//            (test number, done flag, result flag) and the pass value of the
//            result register.
// Revision : 1.0 - initial release
// ============================================================================
package test_mon_pkg;

    // Monitor FSM states, explicitly 3 bits wide with fixed encodings.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } mon_state_e;

    // ISA-test convention registers.
    localparam logic [4:0] REG_TESTNUM = 5'd3;
    localparam logic [4:0] REG_DONE    = 5'd26;
    localparam logic [4:0] REG_RESULT  = 5'd27;

    // Value of the result register that means the test passed.
    localparam int unsigned RESULT_PASS = 1;

endpackage : test_mon_pkg
`default_nettype wire

// File: rtl/test_mon_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : test_mon_sat_cnt
// Purpose  : Enable-gated up-counter that sticks at all-ones instead of
//            wrapping.
// Ports    : clk   - clock, rising edge
//            rst   - asynchronous reset, active low
//            i_en  - count this cycle
//            o_cnt - current count (registered)
// Revision : 1.0 - initial release
// ============================================================================
module test_mon_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        // Stop at all-ones so a very long run never reads back as short.
        if (i_en && (r_cnt_q != '1)) begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_cnt = r_cnt_q;

endmodule : test_mon_sat_cnt
`default_nettype wire

// File: rtl/test_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : test_status_monitor
// Purpose  : End-of-test monitor beside the register file. Snoops the
//            writeback port, shadows x3 (test number) and x27 (result),
//            watches for x26 (done) = 1 and produces sticky done/pass/fail
//            status plus RUN-state cycle and retired-instruction counts.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active low
//            wb_en        - register-file write enable
//            wb_addr      - destination register index
//            wb_data      - value written
//            retire       - one instruction retired this cycle
//            done         - test finished (sticky)
//            pass         - finished with x27 == 1 (sticky)
//            fail         - finished with x27 != 1, or timed out (sticky)
//            timeout      - RUN cycle budget exhausted (sticky)
//            test_num     - current x3 shadow
//            cycle_cnt    - cycles spent in RUN
//            instret_cnt  - retire pulses counted in RUN
// Config   : TEST_STATUS_MONITOR_TIMEOUT_EN - when defined, RUN ends in
//            TIMEOUT after TIMEOUT_CYC cycles; otherwise timeout is tied low
//            and TIMEOUT_CYC has no effect.
// Revision : 1.0 - initial release
// ============================================================================
module test_status_monitor
    import test_mon_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             retire,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  test_num,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    mon_state_e      r_state_q;
    mon_state_e      w_state_d;
    logic [XLEN-1:0] r_sh3_q;
    logic [XLEN-1:0] w_sh3_d;
    logic [XLEN-1:0] r_sh27_q;
    logic [XLEN-1:0] w_sh27_d;

    logic w_live;       // IDLE or RUN: shadows and counters still move
    logic w_in_run;
    logic w_end;        // x26 written with 1 this cycle
    logic w_result_ok;  // result shadow as it stood before this edge

    assign w_live      = (r_state_q == ST_IDLE) || (r_state_q == ST_RUN);
    assign w_in_run    = (r_state_q == ST_RUN);
    assign w_end       = wb_en && (wb_addr == REG_DONE) &&
                         (wb_data == XLEN'(RESULT_PASS));
    assign w_result_ok = (r_sh27_q == XLEN'(RESULT_PASS));

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    test_mon_sat_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_in_run),
        .o_cnt (cycle_cnt)
    );

    // Counting in IDLE as well catches the retire that starts the run.
    test_mon_sat_cnt #(.CNT_W(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_en  (retire && w_live),
        .o_cnt (instret_cnt)
    );

`ifdef TEST_STATUS_MONITOR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_budget_last = CNT_W'(TIMEOUT_CYC - 1);
    logic w_budget_hit;
    assign w_budget_hit = w_in_run && (cycle_cnt == c_budget_last);
`else
    logic w_unused_budget;
    assign w_unused_budget = ^TIMEOUT_CYC;
`endif

    // ------------------------------------------------------------------
    // Shadow registers: frozen once the FSM is terminal so test_num keeps
    // the number of the test that ended the run.
    // ------------------------------------------------------------------
    always_comb begin
        w_sh3_d  = r_sh3_q;
        w_sh27_d = r_sh27_q;
        if (w_live && wb_en) begin
            if (wb_addr == REG_TESTNUM) w_sh3_d  = wb_data;
            if (wb_addr == REG_RESULT)  w_sh27_d = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= ST_IDLE;
            r_sh3_q   <= '0;
            r_sh27_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_sh3_q   <= w_sh3_d;
            r_sh27_q  <= w_sh27_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. The done write takes priority over the budget.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_end) begin
                    w_state_d = w_result_ok ? ST_PASS : ST_FAIL;
                end else if (retire) begin
                    w_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_end) begin
                    w_state_d = w_result_ok ? ST_PASS : ST_FAIL;
                end
`ifdef TEST_STATUS_MONITOR_TIMEOUT_EN
                else if (w_budget_hit) begin
                    w_state_d = ST_TIMEOUT;
                end
`endif
            end
            default: w_state_d = r_state_q;  // terminal until reset
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded straight from the state register
    // ------------------------------------------------------------------
    always_comb begin
        done = (r_state_q == ST_PASS) || (r_state_q == ST_FAIL);
        pass = (r_state_q == ST_PASS);
        fail = (r_state_q == ST_FAIL);
`ifdef TEST_STATUS_MONITOR_TIMEOUT_EN
        done    = done || (r_state_q == ST_TIMEOUT);
        fail    = fail || (r_state_q == ST_TIMEOUT);
        timeout = (r_state_q == ST_TIMEOUT);
`else
        timeout = 1'b0;
`endif
    end

    assign test_num = r_sh3_q;

endmodule : test_status_monitor
`default_nettype wire
